// File: rtl/calc1_resp_aligner.sv
// calc1_resp_aligner
// Pairs up the reference-model and DUV responses for each of the four calc1
// ports so the downstream checker always compares like with like.
//
// For every issued command, each port waits for one response from each side.
// Either side may answer at any latency. The port then emits one aligned pair
// for a single cycle. If a side stays silent for TIMEOUT cycles, the port emits
// a timed-out pair instead, and the missing side is driven as zero.
//
// Ports:
//   c_clk         clock, all logic on the rising edge
//   reset         synchronous active-high reset
//   cmd_issued    [1:4]   per-port command pulse (operand-2 cycle)
//   ref_out_data  [0:127] reference data, port p at bits (p-1)*32 +: 32
//   ref_out_resp  [0:7]   reference resp, port p at bits (p-1)*2 +: 2
//   duv_out_data  [0:127] DUV data, same packing
//   duv_out_resp  [0:7]   DUV resp, same packing
//   pair_valid    [1:4]   one-cycle strobe: aligned pair valid
//   pair_timeout  [1:4]   qualifies pair_valid: a side never answered
//   pair_ref_*/pair_duv_* captured data/resp, zero outside pair_valid
//   spurious_ref/spurious_duv [1:4] response with no slot to land in
//   overlap_err   [1:4]   command issued while the port was still waiting
module calc1_resp_aligner #(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 8
) (
   input  logic         c_clk,
   input  logic         reset,
   input  logic [1:4]   cmd_issued,
   input  logic [0:127] ref_out_data,
   input  logic [0:7]   ref_out_resp,
   input  logic [0:127] duv_out_data,
   input  logic [0:7]   duv_out_resp,
   output logic [1:4]   pair_valid,
   output logic [1:4]   pair_timeout,
   output logic [0:127] pair_ref_data,
   output logic [0:7]   pair_ref_resp,
   output logic [0:127] pair_duv_data,
   output logic [0:7]   pair_duv_resp,
   output logic [1:4]   spurious_ref,
   output logic [1:4]   spurious_duv,
   output logic [1:4]   overlap_err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_EMIT = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   for (genvar p = 1; p <= 4; p++) begin : g_port
      // per-port input slices
      logic [31:0] ref_data_in_s, duv_data_in_s;
      logic [1:0]  ref_resp_in_s, duv_resp_in_s;
      logic        ref_hit_s, duv_hit_s, cmd_s;

      // FSM and capture state
      state_t           state_r, state_s;
      logic [CNT_W-1:0] cnt_r, cnt_s;
      logic             ref_got_r, ref_got_s, duv_got_r, duv_got_s;
      logic [31:0]      ref_data_r, ref_data_s, duv_data_r, duv_data_s;
      logic [1:0]       ref_resp_r, ref_resp_s, duv_resp_r, duv_resp_s;
      logic             timed_out_s, emit_s;
      logic             spur_ref_s, spur_duv_s, ovl_s;

      // registered outputs
      logic             valid_r, to_r, spur_ref_r, spur_duv_r, ovl_r;
      logic [31:0]      o_ref_data_r, o_duv_data_r;
      logic [1:0]       o_ref_resp_r, o_duv_resp_r;

      assign ref_data_in_s = ref_out_data[(p-1)*32 +: 32];
      assign duv_data_in_s = duv_out_data[(p-1)*32 +: 32];
      assign ref_resp_in_s = ref_out_resp[(p-1)*2 +: 2];
      assign duv_resp_in_s = duv_out_resp[(p-1)*2 +: 2];
      assign ref_hit_s     = (ref_resp_in_s != 2'd0);
      assign duv_hit_s     = (duv_resp_in_s != 2'd0);
      assign cmd_s         = cmd_issued[p];

      // next-state, capture and output-pulse logic for this port
      always_comb begin
         state_s     = state_r;
         cnt_s       = cnt_r;
         ref_got_s   = ref_got_r;
         duv_got_s   = duv_got_r;
         ref_data_s  = ref_data_r;
         ref_resp_s  = ref_resp_r;
         duv_data_s  = duv_data_r;
         duv_resp_s  = duv_resp_r;
         timed_out_s = 1'b0;
         spur_ref_s  = 1'b0;
         spur_duv_s  = 1'b0;
         ovl_s       = 1'b0;
         case (state_r)
            // EMIT behaves like IDLE for inputs, which allows back-to-back
            // commands and makes responses in the emit cycle spurious.
            ST_IDLE, ST_EMIT: begin
               spur_ref_s = ref_hit_s;
               spur_duv_s = duv_hit_s;
               if (cmd_s) begin
                  state_s    = ST_WAIT;
                  cnt_s      = {CNT_W{1'b0}};
                  ref_got_s  = 1'b0;
                  duv_got_s  = 1'b0;
                  ref_data_s = 32'd0;
                  ref_resp_s = 2'd0;
                  duv_data_s = 32'd0;
                  duv_resp_s = 2'd0;
               end else begin
                  state_s = ST_IDLE;
               end
            end
            ST_WAIT: begin
               cnt_s = cnt_r + CNT_ONE;
               if (cmd_s) begin
                  ovl_s = 1'b1;
               end else begin
                  ovl_s = 1'b0;
               end
               // first response per side is kept; later ones are spurious
               if (ref_hit_s && ref_got_r) begin
                  spur_ref_s = 1'b1;
               end else if (ref_hit_s) begin
                  ref_got_s  = 1'b1;
                  ref_data_s = ref_data_in_s;
                  ref_resp_s = ref_resp_in_s;
               end else begin
                  spur_ref_s = 1'b0;
               end
               if (duv_hit_s && duv_got_r) begin
                  spur_duv_s = 1'b1;
               end else if (duv_hit_s) begin
                  duv_got_s  = 1'b1;
                  duv_data_s = duv_data_in_s;
                  duv_resp_s = duv_resp_in_s;
               end else begin
                  spur_duv_s = 1'b0;
               end
               // completion uses this cycle's captures, so a late answer in
               // the final cycle still counts
               if (ref_got_s && duv_got_s) begin
                  state_s = ST_EMIT;
               end else if (cnt_r == CNT_LAST) begin
                  state_s     = ST_EMIT;
                  timed_out_s = 1'b1;
               end else begin
                  state_s = ST_WAIT;
               end
            end
            default: begin
               state_s = ST_IDLE;
            end
         endcase
      end

      // the output registers load on the WAIT->EMIT transition so they are
      // visible exactly during the EMIT cycle
      assign emit_s = (state_r == ST_WAIT) && (state_s == ST_EMIT);

      // state, capture and output registers
      always_ff @(posedge c_clk) begin
         if (reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            ref_got_r    <= 1'b0;
            duv_got_r    <= 1'b0;
            ref_data_r   <= 32'd0;
            ref_resp_r   <= 2'd0;
            duv_data_r   <= 32'd0;
            duv_resp_r   <= 2'd0;
            valid_r      <= 1'b0;
            to_r         <= 1'b0;
            spur_ref_r   <= 1'b0;
            spur_duv_r   <= 1'b0;
            ovl_r        <= 1'b0;
            o_ref_data_r <= 32'd0;
            o_ref_resp_r <= 2'd0;
            o_duv_data_r <= 32'd0;
            o_duv_resp_r <= 2'd0;
         end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            ref_got_r    <= ref_got_s;
            duv_got_r    <= duv_got_s;
            ref_data_r   <= ref_data_s;
            ref_resp_r   <= ref_resp_s;
            duv_data_r   <= duv_data_s;
            duv_resp_r   <= duv_resp_s;
            valid_r      <= emit_s;
            to_r         <= emit_s & timed_out_s;
            spur_ref_r   <= spur_ref_s;
            spur_duv_r   <= spur_duv_s;
            ovl_r        <= ovl_s;
            o_ref_data_r <= emit_s ? ref_data_s : 32'd0;
            o_ref_resp_r <= emit_s ? ref_resp_s : 2'd0;
            o_duv_data_r <= emit_s ? duv_data_s : 32'd0;
            o_duv_resp_r <= emit_s ? duv_resp_s : 2'd0;
         end
      end

      assign pair_valid[p]                 = valid_r;
      assign pair_timeout[p]               = to_r;
      assign spurious_ref[p]               = spur_ref_r;
      assign spurious_duv[p]               = spur_duv_r;
      assign overlap_err[p]                = ovl_r;
      assign pair_ref_data[(p-1)*32 +: 32] = o_ref_data_r;
      assign pair_ref_resp[(p-1)*2 +: 2]   = o_ref_resp_r;
      assign pair_duv_data[(p-1)*32 +: 32] = o_duv_data_r;
      assign pair_duv_resp[(p-1)*2 +: 2]   = o_duv_resp_r;
   end

endmodule

// File: tb/tb_calc1_resp_aligner.sv
// Directed bench for calc1_resp_aligner. Stimulus pushes expected output
// events (pair, spurious, overlap) with their expected cycle into a
// scoreboard. An independent monitor pops and compares them on each falling
// edge.
module tb_calc1_resp_aligner;

   localparam int KPAIR = 0;
   localparam int KSREF = 1;
   localparam int KSDUV = 2;
   localparam int KOVL  = 3;

   logic         c_clk;
   logic         reset;
   logic [1:4]   cmd_issued;
   logic [0:127] ref_out_data;
   logic [0:7]   ref_out_resp;
   logic [0:127] duv_out_data;
   logic [0:7]   duv_out_resp;
   logic [1:4]   pair_valid;
   logic [1:4]   pair_timeout;
   logic [0:127] pair_ref_data;
   logic [0:7]   pair_ref_resp;
   logic [0:127] pair_duv_data;
   logic [0:7]   pair_duv_resp;
   logic [1:4]   spurious_ref;
   logic [1:4]   spurious_duv;
   logic [1:4]   overlap_err;

   typedef struct {
      int          at;
      int          port;
      int          kind;
      logic        to;
      logic [1:0]  rr;
      logic [31:0] rd;
      logic [1:0]  dr;
      logic [31:0] dd;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   logic mon_en = 1'b0;

   calc1_resp_aligner #(.TIMEOUT(8), .CNT_W(8)) dut (
      .c_clk        (c_clk),
      .reset        (reset),
      .cmd_issued   (cmd_issued),
      .ref_out_data (ref_out_data),
      .ref_out_resp (ref_out_resp),
      .duv_out_data (duv_out_data),
      .duv_out_resp (duv_out_resp),
      .pair_valid   (pair_valid),
      .pair_timeout (pair_timeout),
      .pair_ref_data(pair_ref_data),
      .pair_ref_resp(pair_ref_resp),
      .pair_duv_data(pair_duv_data),
      .pair_duv_resp(pair_duv_resp),
      .spurious_ref (spurious_ref),
      .spurious_duv (spurious_duv),
      .overlap_err  (overlap_err)
   );

   initial c_clk = 1'b0;
   always #5 c_clk = ~c_clk;

   always @(posedge c_clk) cyc <= cyc + 1;

   function automatic string kname(input int k);
      case (k)
         KPAIR:   return "pair";
         KSREF:   return "spurious_ref";
         KSDUV:   return "spurious_duv";
         default: return "overlap_err";
      endcase
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic nxt();
      @(posedge c_clk);
      #1;
      cmd_issued   = 4'b0000;
      ref_out_resp = 8'h00;
      duv_out_resp = 8'h00;
      ref_out_data = {4{32'hBAD0BAD0}};
      duv_out_data = {4{32'h0DEF0DEF}};
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) nxt();
   endtask

   task automatic set_cmd(input int p);
      cmd_issued[p] = 1'b1;
   endtask

   task automatic set_ref(input int p, input logic [1:0] r, input logic [31:0] d);
      ref_out_resp[(p-1)*2 +: 2]   = r;
      ref_out_data[(p-1)*32 +: 32] = d;
   endtask

   task automatic set_duv(input int p, input logic [1:0] r, input logic [31:0] d);
      duv_out_resp[(p-1)*2 +: 2]   = r;
      duv_out_data[(p-1)*32 +: 32] = d;
   endtask

   task automatic exp_pair(input int p, input int at, input logic to,
                           input logic [1:0] rr, input logic [31:0] rd,
                           input logic [1:0] dr, input logic [31:0] dd);
      exp_t e;
      e.at = at; e.port = p; e.kind = KPAIR; e.to = to;
      e.rr = rr; e.rd = rd; e.dr = dr; e.dd = dd;
      sb.push_back(e);
   endtask

   task automatic exp_flag(input int k, input int p, input int at);
      exp_t e;
      e.at = at; e.port = p; e.kind = k; e.to = 1'b0;
      e.rr = 2'd0; e.rd = 32'd0; e.dr = 2'd0; e.dd = 32'd0;
      sb.push_back(e);
   endtask

   // ---------------- monitor ----------------
   task automatic observe(input int p, input int k);
      int          idx;
      logic        a_to;
      logic [1:0]  a_rr, a_dr;
      logic [31:0] a_rd, a_dd;
      idx = -1;
      for (int i = 0; i < sb.size(); i++)
         if (idx < 0 && sb[i].port == p && sb[i].kind == k && sb[i].at == cyc) idx = i;
      checks++;
      if (idx < 0) begin
         errors++;
         $display("FAIL unexpected_%s port %0d cycle %0d: got strobe, expected none", kname(k), p, cyc);
      end else begin
         if (k == KPAIR) begin
            a_to = pair_timeout[p];
            a_rr = pair_ref_resp[(p-1)*2 +: 2];
            a_rd = pair_ref_data[(p-1)*32 +: 32];
            a_dr = pair_duv_resp[(p-1)*2 +: 2];
            a_dd = pair_duv_data[(p-1)*32 +: 32];
            if (a_to !== sb[idx].to || a_rr !== sb[idx].rr || a_rd !== sb[idx].rd ||
                a_dr !== sb[idx].dr || a_dd !== sb[idx].dd) begin
               errors++;
               $display("FAIL pair_payload port %0d cycle %0d: got to=%0b ref=%0d/%h duv=%0d/%h, expected to=%0b ref=%0d/%h duv=%0d/%h",
                        p, cyc, a_to, a_rr, a_rd, a_dr, a_dd,
                        sb[idx].to, sb[idx].rr, sb[idx].rd, sb[idx].dr, sb[idx].dd);
            end
         end
         sb.delete(idx);
      end
   endtask

   task automatic flush_stale(input int limit);
      int i;
      i = 0;
      while (i < sb.size()) begin
         if (sb[i].at < limit) begin
            checks++;
            errors++;
            $display("FAIL missing_%s port %0d: got nothing, expected at cycle %0d", kname(sb[i].kind), sb[i].port, sb[i].at);
            sb.delete(i);
         end else begin
            i++;
         end
      end
   endtask

   always @(negedge c_clk) begin
      if (mon_en) begin
         flush_stale(cyc);
         for (int p = 1; p <= 4; p++) begin
            if (pair_valid[p] === 1'b1) begin
               observe(p, KPAIR);
            end else begin
               checks++;
               if (pair_timeout[p] !== 1'b0 || pair_ref_resp[(p-1)*2 +: 2] !== 2'd0 ||
                   pair_ref_data[(p-1)*32 +: 32] !== 32'd0 || pair_duv_resp[(p-1)*2 +: 2] !== 2'd0 ||
                   pair_duv_data[(p-1)*32 +: 32] !== 32'd0 || pair_valid[p] !== 1'b0) begin
                  errors++;
                  $display("FAIL idle_fields port %0d cycle %0d: got valid=%b to=%b ref=%h duv=%h, expected all zero",
                           p, cyc, pair_valid[p], pair_timeout[p],
                           pair_ref_data[(p-1)*32 +: 32], pair_duv_data[(p-1)*32 +: 32]);
               end
            end
            if (spurious_ref[p] !== 1'b0) observe(p, KSREF);
            if (spurious_duv[p] !== 1'b0) observe(p, KSDUV);
            if (overlap_err[p]  !== 1'b0) observe(p, KOVL);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   initial begin
      int t;
      reset        = 1'b1;
      cmd_issued   = 4'b0000;
      ref_out_resp = 8'h00;
      duv_out_resp = 8'h00;
      ref_out_data = 128'd0;
      duv_out_data = 128'd0;
      nxt();
      mon_en = 1'b1;   // outputs must already be zero after the first reset edge
      nxt();
      nxt();
      reset = 1'b0;

      // port 1 basic pair, then back-to-back command in the EMIT cycle
      t = cyc;
      set_cmd(1);
      wait_until(t + 3); set_ref(1, 2'd1, 32'h00000005);
      wait_until(t + 5); set_duv(1, 2'd1, 32'h00000005);
      exp_pair(1, t + 6, 1'b0, 2'd1, 32'h00000005, 2'd1, 32'h00000005);
      wait_until(t + 6); set_cmd(1);
      wait_until(t + 8); set_ref(1, 2'd2, 32'hDEAD0001); set_duv(1, 2'd2, 32'hDEAD0002);
      exp_pair(1, t + 9, 1'b0, 2'd2, 32'hDEAD0001, 2'd2, 32'hDEAD0002);
      wait_until(t + 12);

      // port 2 timeout with DUV silent
      t = cyc;
      set_cmd(2);
      wait_until(t + 3); set_ref(2, 2'd2, 32'h12345678);
      exp_pair(2, t + 9, 1'b1, 2'd2, 32'h12345678, 2'd0, 32'd0);
      wait_until(t + 11);

      // port 2: response in issue cycle is spurious; capture in final WAIT cycle
      t = cyc;
      set_cmd(2); set_duv(2, 2'd3, 32'hCAFEF00D);
      exp_flag(KSDUV, 2, t + 1);
      wait_until(t + 8); set_ref(2, 2'd1, 32'hA5A5A5A5);
      exp_pair(2, t + 9, 1'b1, 2'd1, 32'hA5A5A5A5, 2'd0, 32'd0);
      wait_until(t + 11);

      // port 3 simultaneous capture
      t = cyc;
      set_cmd(3);
      wait_until(t + 2); set_ref(3, 2'd1, 32'hFFFFFFFF); set_duv(3, 2'd1, 32'hFFFFFFFF);
      exp_pair(3, t + 3, 1'b0, 2'd1, 32'hFFFFFFFF, 2'd1, 32'hFFFFFFFF);
      wait_until(t + 5);

      // port 3 duplicate ref response keeps first capture
      t = cyc;
      set_cmd(3);
      wait_until(t + 1); set_ref(3, 2'd1, 32'h11111111);
      wait_until(t + 2); set_ref(3, 2'd1, 32'h22222222);
      exp_flag(KSREF, 3, t + 3);
      wait_until(t + 4); set_duv(3, 2'd1, 32'h33333333);
      exp_pair(3, t + 5, 1'b0, 2'd1, 32'h11111111, 2'd1, 32'h33333333);
      wait_until(t + 7);

      // port 4 spurious DUV in idle, overlapping command
      t = cyc;
      set_duv(4, 2'd3, 32'h0BADBEEF);
      exp_flag(KSDUV, 4, t + 1);
      wait_until(t + 2); set_cmd(4);
      wait_until(t + 4); set_cmd(4);
      exp_flag(KOVL, 4, t + 5);
      wait_until(t + 5); set_ref(4, 2'd1, 32'h44444444);
      wait_until(t + 6); set_duv(4, 2'd2, 32'h55555555);
      exp_pair(4, t + 7, 1'b0, 2'd1, 32'h44444444, 2'd2, 32'h55555555);
      wait_until(t + 10);

      // all ports issued, reset mid-WAIT, later responses are spurious
      t = cyc;
      for (int p = 1; p <= 4; p++) set_cmd(p);
      wait_until(t + 2);
      reset = 1'b1;
      set_ref(1, 2'd1, 32'h77777777);
      wait_until(t + 3);
      reset = 1'b0;
      wait_until(t + 5);
      for (int p = 1; p <= 4; p++) begin
         set_ref(p, 2'd1, 32'h60000000 + 32'(p));
         set_duv(p, 2'd2, 32'h70000000 + 32'(p));
         exp_flag(KSREF, p, t + 6);
         exp_flag(KSDUV, p, t + 6);
      end
      wait_until(t + 10);

      @(posedge c_clk);
      #1;
      flush_stale(cyc + 1000);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
